// File: rtl/hc_mmio_rd_responder_pkg.sv
// HardCloud AFU MMIO read-side types, CSR offsets and read decoder.
// Shared by the responder, its bus interface and the bench.
package hc_mmio_rd_responder_pkg;

    localparam logic [17:0] HC_AFU_DFH  = 18'h000;
    localparam logic [17:0] HC_AFU_ID_L = 18'h008;
    localparam logic [17:0] HC_AFU_ID_H = 18'h010;
    localparam logic [17:0] HC_STATUS   = 18'h100;
    localparam logic [17:0] HC_SCRATCH  = 18'h108;
    localparam logic [17:0] HC_DSM      = 18'h110;
    localparam logic [17:0] HC_CONTROL  = 18'h118;
    localparam logic [17:0] HC_BUF_BASE = 18'h120;

    typedef struct packed {
        logic [15:0] address;
        logic [1:0]  length;
        logic        rsvd;
        logic [8:0]  tid;
    } t_ccip_c0_ReqMmioHdr;

    typedef struct packed {
        t_ccip_c0_ReqMmioHdr hdr;
        logic [63:0]         data;
        logic                mmioRdValid;
        logic                mmioWrValid;
    } t_if_ccip_c0_Rx;

    typedef struct packed {
        logic [8:0] tid;
    } t_ccip_c2_RspMmioHdr;

    typedef struct packed {
        t_ccip_c2_RspMmioHdr hdr;
        logic                mmioRdValid;
        logic [63:0]         data;
    } t_if_ccip_c2_Tx;

    typedef struct packed {
        logic [63:0] address;
        logic [31:0] size;
    } t_hc_buffer;

    typedef struct packed {
        logic [15:0] rd_count;
        logic [43:0] rsvd;
        logic        err;
        logic        done;
        logic        busy;
        logic        alive;
    } t_hc_status;

    typedef enum logic [3:0] {
        SEL_DFH, SEL_IDL, SEL_IDH, SEL_STAT, SEL_SCR,
        SEL_DSM, SEL_CTL, SEL_BADDR, SEL_BSIZE, SEL_ZERO
    } t_hc_rd_sel;

    typedef struct packed {
        t_hc_rd_sel sel;
        logic [7:0] idx;
    } t_hc_rd_dec;

    function automatic t_hc_rd_dec hc_rd_decode(
        input t_ccip_c0_ReqMmioHdr hdr,
        input int unsigned         nbuf
    );
        t_hc_rd_dec d;
        logic [17:0] off;
        logic [8:0]  q;
        logic [8:0]  rel;
        logic        in_buf;
        off    = {hdr.address, 2'b00};
        q      = off[11:3];
        rel    = q - HC_BUF_BASE[11:3];
        in_buf = (q >= HC_BUF_BASE[11:3]) &&
                 ({24'h0, rel[8:1]} < nbuf);
        d.sel  = SEL_ZERO;
        d.idx  = rel[8:1];
        // Anything beyond the 4KB CSR window reads as zero
        if (off[17:12] == 6'h0) begin
            unique case (1'b1)
                q == HC_AFU_DFH[11:3]:  d.sel = SEL_DFH;
                q == HC_AFU_ID_L[11:3]: d.sel = SEL_IDL;
                q == HC_AFU_ID_H[11:3]: d.sel = SEL_IDH;
                q == HC_STATUS[11:3]:   d.sel = SEL_STAT;
                q == HC_SCRATCH[11:3]:  d.sel = SEL_SCR;
                q == HC_DSM[11:3]:      d.sel = SEL_DSM;
                q == HC_CONTROL[11:3]:  d.sel = SEL_CTL;
                in_buf: d.sel = rel[0] ? SEL_BSIZE : SEL_BADDR;
                default:                d.sel = SEL_ZERO;
            endcase
        end
        return d;
    endfunction

endpackage

// File: rtl/hc_mmio_rd_responder_if.sv
// CCI-P MMIO bus bundle: c0 Rx requests in, c2 Tx read responses out.
// master = host side, slave = AFU responder.
interface hc_mmio_rd_responder_if
    import hc_mmio_rd_responder_pkg::*;
    ;
    t_if_ccip_c0_Rx rx_mmio;
    t_if_ccip_c2_Tx tx_mmio;

    modport master (output rx_mmio, input tx_mmio);
    modport slave  (input rx_mmio, output tx_mmio);
endinterface

// File: rtl/hc_mmio_rd_responder.sv
// AFU CSR read responder: fixed 2-cycle MMIO read pipeline, plus the
// STATUS stickies, read counter and scratch register it owns.
module hc_mmio_rd_responder
    import hc_mmio_rd_responder_pkg::*;
#(
    parameter int          HC_BUFFER_SIZE = 2,
    parameter logic [63:0] AFU_ID_L       = 64'h0,
    parameter logic [63:0] AFU_ID_H       = 64'h0,
    parameter logic [63:0] AFU_DFH        = 64'h1000_0000_0000_0000
) (
    input  logic                   clk,
    input  logic                   reset_n,
    hc_mmio_rd_responder_if.slave  mmio,
    input  logic [63:0]            csr_dsm_base,
    input  logic [31:0]            csr_control,
    input  t_hc_buffer             csr_buffer [HC_BUFFER_SIZE],
    input  logic                   stat_busy,
    input  logic                   stat_done,
    input  logic                   stat_error
);

    localparam int BW = (HC_BUFFER_SIZE > 1) ?
                        $clog2(HC_BUFFER_SIZE) : 1;

    t_hc_rd_dec  dec;
    t_hc_status  stat;
    logic [BW-1:0] bidx;
    logic [63:0] rd_data;
    logic        wr_stat;
    logic        wr_scr;

    logic [63:0] scratch;
    logic        done_q;
    logic        err_q;
    logic [15:0] rd_count;

    logic        s1_valid;
    logic [8:0]  s1_tid;
    logic [1:0]  s1_len;
    logic        s1_hi;
    logic        s1_stat;
    logic [63:0] s1_data;
    logic [63:0] s2_full;
    logic [63:0] s2_data;

    logic        unused_ok;

    assign dec  = hc_rd_decode(mmio.rx_mmio.hdr, HC_BUFFER_SIZE);
    assign bidx = dec.idx[BW-1:0];
    assign unused_ok = ^{mmio.rx_mmio.hdr.rsvd, dec.idx};

    assign wr_stat = mmio.rx_mmio.mmioWrValid &&
                     (mmio.rx_mmio.hdr.address == HC_STATUS[17:2]);
    assign wr_scr  = mmio.rx_mmio.mmioWrValid &&
                     (mmio.rx_mmio.hdr.address == HC_SCRATCH[17:2]) &&
                     (mmio.rx_mmio.hdr.length == 2'b01);

    always_comb begin
        stat       = '0;
        stat.alive = 1'b1;
        stat.busy  = stat_busy;
        stat.done  = done_q;
        stat.err   = err_q;
        rd_data    = '0;
        unique case (dec.sel)
            SEL_DFH:   rd_data = AFU_DFH;
            SEL_IDL:   rd_data = AFU_ID_L;
            SEL_IDH:   rd_data = AFU_ID_H;
            SEL_STAT:  rd_data = stat;
            SEL_SCR:   rd_data = scratch;
            SEL_DSM:   rd_data = {32'h0, csr_dsm_base[31:0]};
            SEL_CTL:   rd_data = {32'h0, csr_control};
            SEL_BADDR: rd_data = csr_buffer[bidx].address;
            SEL_BSIZE: rd_data = {32'h0, csr_buffer[bidx].size};
            default:   rd_data = '0;
        endcase
    end

    // Count is inserted at issue so it reflects every earlier response
    always_comb begin
        s2_full = s1_data;
        if (s1_stat) s2_full[63:48] = rd_count;
        s2_data = s2_full;
        if (s1_len == 2'b00)
            s2_data = {32'h0, s1_hi ? s2_full[63:32] : s2_full[31:0]};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scratch <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (wr_scr) scratch <= mmio.rx_mmio.data;
            done_q <= stat_done |
                      (done_q & ~(wr_stat & mmio.rx_mmio.data[2]));
            err_q  <= stat_error |
                      (err_q & ~(wr_stat & mmio.rx_mmio.data[3]));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid                 <= 1'b0;
            s1_tid                   <= '0;
            s1_len                   <= '0;
            s1_hi                    <= 1'b0;
            s1_stat                  <= 1'b0;
            s1_data                  <= '0;
            mmio.tx_mmio.mmioRdValid <= 1'b0;
            mmio.tx_mmio.hdr.tid     <= '0;
            mmio.tx_mmio.data        <= '0;
            rd_count                 <= '0;
        end else begin
            s1_valid                 <= mmio.rx_mmio.mmioRdValid;
            s1_tid                   <= mmio.rx_mmio.hdr.tid;
            s1_len                   <= mmio.rx_mmio.hdr.length;
            s1_hi                    <= mmio.rx_mmio.hdr.address[0];
            s1_stat                  <= (dec.sel == SEL_STAT);
            s1_data                  <= rd_data;
            mmio.tx_mmio.mmioRdValid <= s1_valid;
            mmio.tx_mmio.hdr.tid     <= s1_tid;
            mmio.tx_mmio.data        <= s2_data;
            if (s1_valid) rd_count <= rd_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_hc_mmio_rd_responder.sv
// Bench for hc_mmio_rd_responder: directed CSR scenarios plus random
// traffic, checked against a byte-offset CSR map model and response queue.
module tb_hc_mmio_rd_responder;
    import hc_mmio_rd_responder_pkg::*;

    localparam int          NB  = 2;
    localparam logic [63:0] IDL = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] IDH = 64'hFEDC_BA98_7654_3210;
    localparam logic [63:0] DFH = 64'h1000_0000_0000_0000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [63:0] csr_dsm_base = 64'h0;
    logic [31:0] csr_control = 32'h0;
    t_hc_buffer  csr_buffer [NB];
    logic        stat_busy = 1'b0;
    logic        stat_done = 1'b0;
    logic        stat_error = 1'b0;

    hc_mmio_rd_responder_if bus();

    hc_mmio_rd_responder #(
        .HC_BUFFER_SIZE(NB),
        .AFU_ID_L(IDL),
        .AFU_ID_H(IDH),
        .AFU_DFH(DFH)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .mmio(bus.slave),
        .csr_dsm_base(csr_dsm_base),
        .csr_control(csr_control),
        .csr_buffer(csr_buffer),
        .stat_busy(stat_busy),
        .stat_done(stat_done),
        .stat_error(stat_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0]  tid;
        logic [63:0] base;
        logic        stat;
        logic [1:0]  len;
        logic        hi;
        int          due;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          n_rsp = 0;
    logic [63:0] m_scr = 64'h0;
    logic        m_done = 1'b0;
    logic        m_err = 1'b0;
    logic [15:0] m_cnt = 16'h0;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Expected 64b register contents at a byte offset (count field 0)
    function automatic logic [63:0] ref_qword(int o);
        int qq;
        int r;
        qq = o & ~7;
        if (o >= 'h1000) return 64'h0;
        case (qq)
            'h000: return DFH;
            'h008: return IDL;
            'h010: return IDH;
            'h100: return {60'h0, m_err, m_done, stat_busy, 1'b1};
            'h108: return m_scr;
            'h110: return {32'h0, csr_dsm_base[31:0]};
            'h118: return {32'h0, csr_control};
            default: begin
                r = qq - 'h120;
                if (r >= 0 && r < 16 * NB) begin
                    if (r % 16 == 0) return csr_buffer[r / 16].address;
                    return {32'h0, csr_buffer[r / 16].size};
                end
                return 64'h0;
            end
        endcase
    endfunction

    task automatic drive(input logic rv, input logic wv,
                         input logic [15:0] a, input logic [1:0] l,
                         input logic [8:0] t, input logic [63:0] d);
        bus.rx_mmio.mmioRdValid = rv;
        bus.rx_mmio.mmioWrValid = wv;
        bus.rx_mmio.hdr.address = a;
        bus.rx_mmio.hdr.length  = l;
        bus.rx_mmio.hdr.rsvd    = 1'b0;
        bus.rx_mmio.hdr.tid     = t;
        bus.rx_mmio.data        = d;
    endtask

    task automatic check_tx();
        exp_t        e;
        logic [63:0] full;
        logic [63:0] exp;
        if (bus.tx_mmio.mmioRdValid) begin
            n_rsp++;
            if (q.size() == 0) begin
                chk("spurious_rsp", 64'd1, 64'd0);
            end else begin
                e = q.pop_front();
                full = e.base;
                if (e.stat) full[63:48] = m_cnt;
                exp = full;
                if (e.len == 2'b00)
                    exp = {32'h0, e.hi ? full[63:32] : full[31:0]};
                chk("rsp_cycle", 64'(cyc), 64'(e.due));
                chk("rsp_tid", 64'(bus.tx_mmio.hdr.tid), 64'(e.tid));
                chk("rsp_data", bus.tx_mmio.data, exp);
                m_cnt++;
            end
        end else if (q.size() > 0 && q[0].due <= cyc) begin
            chk("rsp_missing", 64'd0, 64'd1);
            void'(q.pop_front());
        end
    endtask

    task automatic step();
        exp_t        e;
        logic [15:0] a;
        logic [63:0] d;
        a = bus.rx_mmio.hdr.address;
        d = bus.rx_mmio.data;
        if (bus.rx_mmio.mmioRdValid) begin
            e.tid  = bus.rx_mmio.hdr.tid;
            e.base = ref_qword(int'({a, 2'b00}));
            e.stat = (int'({a, 2'b00}) & ~7) == 'h100;
            e.len  = bus.rx_mmio.hdr.length;
            e.hi   = a[0];
            e.due  = cyc + 2;
            q.push_back(e);
        end
        if (bus.rx_mmio.mmioWrValid) begin
            if (a == 16'h42 && bus.rx_mmio.hdr.length == 2'b01)
                m_scr = d;
            if (a == 16'h40) begin
                if (d[2]) m_done = 1'b0;
                if (d[3]) m_err = 1'b0;
            end
        end
        if (stat_done) m_done = 1'b1;
        if (stat_error) m_err = 1'b1;
        @(posedge clk);
        cyc++;
        #1;
        check_tx();
        @(negedge clk);
        drive(1'b0, 1'b0, 16'h0, 2'b01, 9'h0, 64'h0);
        stat_done  = 1'b0;
        stat_error = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic rd(input logic [17:0] off, input logic [1:0] l,
                      input logic [8:0] t);
        drive(1'b1, 1'b0, off[17:2], l, t, 64'h0);
        step();
    endtask

    task automatic wr(input logic [17:0] off, input logic [63:0] d);
        drive(1'b0, 1'b1, off[17:2], 2'b01, 9'h0, d);
        step();
    endtask

    logic [17:0] offs [20] = '{
        18'h000, 18'h008, 18'h010, 18'h018, 18'h020,
        18'h100, 18'h104, 18'h108, 18'h10C, 18'h110,
        18'h118, 18'h120, 18'h128, 18'h130, 18'h13C,
        18'h140, 18'h148, 18'h800, 18'h1400, 18'h0FF8
    };

    initial begin
        int          op;
        int          base;
        logic [17:0] o;
        csr_buffer[0] = '{address: 64'hAAAA_0000_1234_5678, size: 32'h111};
        csr_buffer[1] = '{address: 64'h0, size: 32'h0};
        drive(1'b0, 1'b0, 16'h0, 2'b01, 9'h0, 64'h0);
        repeat (3) @(negedge clk);
        chk("rst_valid", 64'(bus.tx_mmio.mmioRdValid), 64'd0);
        chk("rst_tid", 64'(bus.tx_mmio.hdr.tid), 64'd0);
        chk("rst_data", bus.tx_mmio.data, 64'h0);
        reset_n = 1'b1;

        rd(18'h000, 2'b01, 9'd5);
        rd(18'h008, 2'b01, 9'd6);
        rd(18'h010, 2'b01, 9'd7);
        idle(3);

        wr(18'h108, 64'hDEAD_BEEF_0123_4567);
        rd(18'h108, 2'b01, 9'd8);
        rd(18'h10C, 2'b00, 9'd9);
        idle(3);

        wr(18'h108, 64'h1);
        drive(1'b1, 1'b1, 16'h42, 2'b01, 9'd10, 64'h2);
        step();
        rd(18'h108, 2'b01, 9'd11);
        idle(3);

        csr_buffer[1] = '{address: 64'h1000, size: 32'h40};
        base = n_rsp;
        for (int i = 0; i < 20; i++) begin
            case (i % 4)
                0: o = 18'h130;
                1: o = 18'h138;
                2: o = 18'h800;
                default: o = 18'h1400;
            endcase
            rd(o, 2'b01, 9'(20 + i));
        end
        idle(3);
        chk("burst_count", 64'(n_rsp - base), 64'd20);

        stat_done = 1'b1;
        step();
        rd(18'h100, 2'b01, 9'd50);
        wr(18'h100, 64'h4);
        rd(18'h100, 2'b01, 9'd51);
        stat_error = 1'b1;
        step();
        stat_error = 1'b1;
        drive(1'b0, 1'b1, 16'h40, 2'b01, 9'h0, 64'h8);
        step();
        rd(18'h100, 2'b01, 9'd52);
        wr(18'h100, 64'h8);
        rd(18'h100, 2'b01, 9'd53);
        idle(3);

        for (int i = 0; i < 400; i++) begin
            op = int'($urandom_range(0, 3));
            stat_busy  = 1'($urandom);
            stat_done  = ($urandom_range(0, 7) == 0);
            stat_error = ($urandom_range(0, 7) == 0);
            if (i % 50 == 0) begin
                csr_dsm_base = {$urandom, $urandom};
                csr_control  = $urandom;
                csr_buffer[0] = '{address: {$urandom, $urandom},
                                  size: $urandom};
            end
            o = offs[$urandom_range(0, 19)];
            if (op >= 2) o = ($urandom_range(0, 1) == 1) ?
                             18'h100 : 18'h108;
            case (op)
                0: drive(1'b0, 1'b0, 16'h0, 2'b01, 9'h0, 64'h0);
                1: drive(1'b1, 1'b0, o[17:2], 2'($urandom_range(0, 3)),
                         9'($urandom), 64'h0);
                2: drive(1'b0, 1'b1, o[17:2], 2'($urandom_range(0, 1)),
                         9'h0, {$urandom, $urandom});
                default: drive(1'b1, 1'b1, o[17:2],
                               2'($urandom_range(0, 1)), 9'($urandom),
                               {$urandom, $urandom});
            endcase
            step();
        end
        stat_busy = 1'b0;
        idle(3);

        force dut.rd_count = 16'hFFFF;
        #1;
        release dut.rd_count;
        m_cnt = 16'hFFFF;
        rd(18'h100, 2'b01, 9'd60);
        rd(18'h100, 2'b01, 9'd61);
        rd(18'h104, 2'b00, 9'd62);
        idle(3);

        rd(18'h000, 2'b01, 9'd70);
        drive(1'b1, 1'b0, 16'h2, 2'b01, 9'd71, 64'h0);
        #1;
        reset_n = 1'b0;
        #1;
        q.delete();
        m_cnt  = 16'h0;
        m_scr  = 64'h0;
        m_done = 1'b0;
        m_err  = 1'b0;
        chk("midrst_valid", 64'(bus.tx_mmio.mmioRdValid), 64'd0);
        drive(1'b0, 1'b0, 16'h0, 2'b01, 9'h0, 64'h0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            cyc++;
            #1;
            chk("midrst_hold", 64'(bus.tx_mmio.mmioRdValid), 64'd0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        idle(1);
        rd(18'h100, 2'b01, 9'd80);
        rd(18'h108, 2'b01, 9'd81);
        idle(3);
        chk("drain", 64'(q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
